// File: rtl/dit_timing_miter_monitor.sv
// Timing-observable miter monitor for a pair of functional-unit copies.
// Tracks a bounded window, latches the first divergence (window cycle and
// lowest mismatching channel) and counts output-valid events on both copies.
module dit_timing_miter_monitor #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned WINDOW = 64,
    parameter int unsigned EV_CH  = 0
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_arm,
    input  logic                                         i_clear,
    input  logic [NUM_CH-1:0]                            i_ch_mask,
    input  logic [NUM_CH-1:0]                            i_obs_a,
    input  logic [NUM_CH-1:0]                            i_obs_b,
    output logic                                         o_tracking,
    output logic                                         o_pass,
    output logic                                         o_diverged,
    output logic [CNT_W-1:0]                             o_div_cycle,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_div_ch,
    output logic [CNT_W-1:0]                             o_cycle_cnt,
    output logic [CNT_W-1:0]                             o_ev_cnt_a,
    output logic [CNT_W-1:0]                             o_ev_cnt_b
);

    localparam int unsigned      DCH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_PASS,
        S_DIV
    } state_t;

    state_t             r_state;
    logic               r_tracking;
    logic               r_pass;
    logic               r_diverged;
    logic [CNT_W-1:0]   r_div_cycle;
    logic [DCH_W-1:0]   r_div_ch;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_ev_cnt_a;
    logic [CNT_W-1:0]   r_ev_cnt_b;

    logic [NUM_CH-1:0]  w_mm;
    logic               w_any_mm;
    logic [DCH_W-1:0]   w_low_ch;

    // Mismatch vector over compared channels and its lowest set index
    always_comb begin
        w_mm     = (i_obs_a ^ i_obs_b) & i_ch_mask;
        w_any_mm = |w_mm;
        w_low_ch = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (w_mm[i]) begin
                w_low_ch = DCH_W'(i);
            end
        end
    end

    // Monitor FSM with registered state decodes, counters and divergence record
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_tracking  <= 1'b0;
            r_pass      <= 1'b0;
            r_diverged  <= 1'b0;
            r_div_cycle <= '0;
            r_div_ch    <= '0;
            r_cycle_cnt <= '0;
            r_ev_cnt_a  <= '0;
            r_ev_cnt_b  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_arm && !i_clear) begin
                        r_state     <= S_TRACK;
                        r_tracking  <= 1'b1;
                        r_cycle_cnt <= '0;
                        r_ev_cnt_a  <= '0;
                        r_ev_cnt_b  <= '0;
                        r_div_cycle <= '0;
                        r_div_ch    <= '0;
                    end
                end
                S_TRACK: begin
                    // Events count on every tracked cycle, saturating at all-ones
                    if (i_obs_a[EV_CH] && (r_ev_cnt_a != CNT_MAX)) begin
                        r_ev_cnt_a <= r_ev_cnt_a + CNT_W'(1);
                    end
                    if (i_obs_b[EV_CH] && (r_ev_cnt_b != CNT_MAX)) begin
                        r_ev_cnt_b <= r_ev_cnt_b + CNT_W'(1);
                    end
                    if (i_clear) begin
                        r_state    <= S_IDLE;
                        r_tracking <= 1'b0;
                    end else if (w_any_mm) begin
                        r_state     <= S_DIV;
                        r_tracking  <= 1'b0;
                        r_diverged  <= 1'b1;
                        r_div_cycle <= r_cycle_cnt;
                        r_div_ch    <= w_low_ch;
                    end else if (r_cycle_cnt == LAST_CYC) begin
                        r_state    <= S_PASS;
                        r_tracking <= 1'b0;
                        r_pass     <= 1'b1;
                    end else begin
                        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                    end
                end
                S_PASS, S_DIV: begin
                    if (i_clear) begin
                        r_state    <= S_IDLE;
                        r_pass     <= 1'b0;
                        r_diverged <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tracking <= 1'b0;
                    r_pass     <= 1'b0;
                    r_diverged <= 1'b0;
                end
            endcase
        end
    end

    assign o_tracking  = r_tracking;
    assign o_pass      = r_pass;
    assign o_diverged  = r_diverged;
    assign o_div_cycle = r_div_cycle;
    assign o_div_ch    = r_div_ch;
    assign o_cycle_cnt = r_cycle_cnt;
    assign o_ev_cnt_a  = r_ev_cnt_a;
    assign o_ev_cnt_b  = r_ev_cnt_b;

endmodule

// File: doc/dit_timing_miter_monitor.md
Name: dit_timing_miter_monitor

Overview:
- Sequential companion to the two-copy data-independent-timing miters used for functional-unit checking.
- Sits beside two instances of one functional unit. The instances share all control inputs and receive different secret data.
- Compares NUM_CH per-cycle timing observables (valid, ready, busy, exception strobes) of both copies over a bounded tracking window.
- Records the first divergence (cycle and channel) and reports pass/fail, so it can be used both as a simulation checker and as a formal observation point.

Parameters:
- NUM_CH, 4, number of timing observables compared per copy.
- CNT_W, 16, width of cycle and event counters.
- WINDOW, 64, tracking window length in cycles; legal range 1 .. 2^CNT_W-1.
- EV_CH, 0, index of the observable counted as the "event" (output-valid) channel.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- arm  in  1  one-cycle pulse; starts tracking from IDLE.
- clear  in  1  returns the FSM to IDLE from any state.
- ch_mask  in  NUM_CH  1 = channel compared; sampled every cycle.
- obs_a  in  NUM_CH  timing observables of copy A.
- obs_b  in  NUM_CH  timing observables of copy B.
- tracking  out  1  high in TRACK.
- pass  out  1  high in PASS.
- diverged  out  1  high in DIVERGED.
- div_cycle  out  CNT_W  window cycle index of the first mismatch.
- div_ch  out  $clog2(NUM_CH) (min 1)  lowest mismatching channel index.
- cycle_cnt  out  CNT_W  cycles elapsed in the current window.
- ev_cnt_a  out  CNT_W  copy-A events on EV_CH during the window.
- ev_cnt_b  out  CNT_W  copy-B events on EV_CH during the window.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - All outputs and counters go to 0.
  - Reset mid-window discards everything; no result is retained.
- Mismatch vector: mm = (obs_a ^ obs_b) & ch_mask. It is combinational and evaluated only in TRACK.
- States and transitions (registered, one per cycle):
  - IDLE: arm=1 and clear=0 -> TRACK. On entry, cycle_cnt, ev_cnt_a and ev_cnt_b are zeroed.
  - TRACK, |mm|=1 -> DIVERGED:
    - div_cycle <= cycle_cnt.
    - div_ch <= index of the lowest set bit of mm.
  - TRACK, |mm|=0 and cycle_cnt == WINDOW-1 -> PASS.
  - TRACK otherwise: cycle_cnt increments by 1.
  - DIVERGED and PASS hold until clear=1, then -> IDLE.
- The event counters increment in TRACK, including the last window cycle and the mismatch cycle:
  - ev_cnt_a increments when obs_a[EV_CH]=1.
  - ev_cnt_b increments when obs_b[EV_CH]=1.
  - Both saturate at all-ones and never wrap.
- cycle_cnt never exceeds WINDOW-1. It is frozen in DIVERGED and PASS.
- div_cycle and div_ch:
  - Written only on the TRACK->DIVERGED transition.
  - Hold until the next entry to TRACK, which zeroes them.
- Simultaneous events:
  - clear together with arm in IDLE: stay in IDLE (clear wins).
  - clear in TRACK: go to IDLE; the mismatch is not captured.
  - Mismatch on the window's last cycle: DIVERGED, not PASS.
  - arm in TRACK, DIVERGED or PASS: ignored.
- Observables in IDLE are ignored entirely.
- Masked channels (ch_mask bit 0) never cause divergence, even if they toggle.
- Outputs tracking, pass and diverged are registered decodes of the state. Exactly one of them is high outside IDLE, and all are 0 in IDLE.
- Latency: a mismatch at window cycle k shows diverged=1 and div_cycle=k on the following rising edge.
- NUM_CH=1: div_ch is 1 bit and always 0.

Test Plan:
- Identical streams: WINDOW=64, arm, obs_a=obs_b random for 64 cycles -> pass=1 after exactly 64 tracking cycles; cycle_cnt=63; ev_cnt_a=ev_cnt_b.
- Single-channel skew: obs_b[2] delayed one cycle from obs_a[2] at window cycle 10 -> diverged=1; div_cycle=10; div_ch=2; later mismatches change nothing.
- Multi-channel mismatch and masking:
  - mm=4'b1010 at cycle 5 -> div_ch=1.
  - Repeat with ch_mask=4'b1101 -> div_ch=3.
  - With ch_mask=0 -> pass.
- Boundary: mismatch only at cycle 63 -> DIVERGED with div_cycle=63; arm and clear together in IDLE -> stays IDLE; clear during TRACK -> IDLE, all flags 0.
- Reset mid-window: assert reset asynchronously at cycle 20 of TRACK -> all outputs 0 immediately, before the next clock edge; re-arm -> counters start from 0.
- Saturation: CNT_W=4, WINDOW=15, obs_a[EV_CH]=1 every cycle -> ev_cnt_a=15 (saturated, not wrapped); pass=1.
